cube_layer_driver: RTL
======================

Name: cube_layer_driver

Overview:
- Downstream display stage for the 8x8x8 LED cube.
- Consumes the 512-bit Cells vector produced by conway_sim.
- Double-buffers one full frame and scans the cube one layer at a time. For each layer it serially shifts 64 column bits into external shift registers, latches them, then enables that layer's driver.
- Owns all cube-facing timing, so the simulator may update Cells at any time without tearing the display.

Parameters:
- CLK_DIV, 4: system cycles per SerClk half-period (>=1).
- ON_CYCLES, 50000: cycles a layer stays enabled (>=1).
- BLANK_CYCLES, 16: all-layers-off cycles before each layer shift (>=1).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- Cells  in  512  cell states; bit index = z*64 + y*8 + x; 1 = lit.
- FrameValid  in  1  one-cycle strobe: Cells holds a new complete generation.
- FrameAck  out  1  one-cycle pulse when a frame is transferred into the display buffer.
- SerData  out  1  serial column data.
- SerClk  out  1  shift clock to external registers; data sampled on rising edge.
- SerLatch  out  1  storage-register latch, active-high.
- LayerEn  out  8  one-hot layer enable, active-high; bit z = layer z.
- Layer  out  3  index of the layer currently being loaded or displayed.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - Staging buffer, display buffer and pending flag cleared (cube dark).
  - State BLANK, Layer=0, counters 0.
  - All outputs 0 from the following cycle.
  - Applies mid-shift or mid-display; no partial latch pulse may follow.
- Staging:
  - FrameValid=1 copies Cells into the 512-bit staging register and sets pending.
  - A later FrameValid before transfer overwrites staging, so the newest frame wins.
- Transfer happens only on entry to BLANK with Layer=0 (frame boundary), and only if pending or FrameValid is set that cycle:
  - If FrameValid=1 in the same cycle, the display buffer loads directly from Cells.
  - Otherwise it loads from staging.
  - Pending clears and FrameAck pulses one cycle later.
  - With no pending frame, the display buffer keeps the old frame.
- State machine:
  - BLANK: LayerEn=0 for BLANK_CYCLES, then go to SHIFT.
  - SHIFT: 64 bits of display[Layer*64 +: 64], sent MSB (bit 63) first.
    - Per bit: SerData updates while SerClk is 0. SerClk stays low CLK_DIV cycles, then high CLK_DIV cycles.
    - Total 128*CLK_DIV cycles; SerClk returns to 0, then go to LATCH.
  - LATCH: SerLatch=1 for CLK_DIV cycles, then go to DISPLAY.
  - DISPLAY: LayerEn = 1<<Layer for ON_CYCLES. Then Layer increments (7 wraps to 0) and the state goes to BLANK.
- Layer period = BLANK_CYCLES + 130*CLK_DIV + ON_CYCLES. Frame period = 8x that.
- LayerEn is never non-zero outside DISPLAY; at most one bit is ever set.
- SerData=0 outside SHIFT. SerClk and SerLatch are never high simultaneously.
- All outputs are registered (glitch-free to pins).

Decomposition:
- Shared package cube_pkg:
  - CUBE_DIM=8, LAYER_BITS=64, CELL_BITS=512.
  - Driver state encoding: BLANK, SHIFT, LATCH, DISPLAY.
  - Function cell_index(x,y,z).
- One sub-module, cube_shift_serializer:
  - Inputs: start pulse, 64-bit word, CLK_DIV.
  - Outputs: SerData, SerClk, done pulse.
  - Owns the bit counter and half-period counter.
- Top level holds the buffers, frame handshake, layer counter and FSM.

Test Plan (CLK_DIV=2, ON_CYCLES=20, BLANK_CYCLES=4 -> layer period 284, frame 2272 cycles):
- Reset then idle:
  - LayerEn scans 01,02,...,80, each high exactly 20 cycles, 284 cycles apart.
  - SerData always 0; FrameAck never pulses.
- Cells bit 0 only (x=y=z=0) with FrameValid:
  - FrameAck pulses at the next layer-0 boundary.
  - In the layer-0 shift, the 64th bit (last rising SerClk) is 1; other layers shift all 0s.
- Cells with layer 3 = 64'hA5A5_0000_0000_00FF:
  - Captured serial stream at SerClk rises during Layer=3 equals that word MSB-first.
  - Exactly 64 rising edges, then one 2-cycle SerLatch pulse.
- FrameValid with frame A during layer 5, frame B during layer 6:
  - Single FrameAck at the boundary; displayed layer-0 data is B.
- FrameValid asserted exactly on the boundary cycle with frame C (staging holds stale D):
  - Display loads C; FrameAck follows 1 cycle later.
- Reset pulled low midway through SHIFT of layer 2:
  - Next cycle all outputs 0.
  - After release, the scan restarts at layer 0 with a dark cube.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared definitions for the LED cube display path: geometry, driver
// state encoding and small indexing helpers.
package cube_pkg;

   localparam int CUBE_DIM   = 8;
   localparam int LAYER_BITS = 64;
   localparam int CELL_BITS  = 512;

   // Layer driver sequence: dark gap, column shift, latch, layer on.
   typedef enum logic [1:0] {
      ST_BLANK   = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_LATCH   = 2'd2,
      ST_DISPLAY = 2'd3
   } drv_state_e;

   // Flat bit position of cell (x,y,z) inside the 512-bit Cells vector.
   function automatic logic [8:0] cell_index(input logic [2:0] x,
                                             input logic [2:0] y,
                                             input logic [2:0] z);
      return {z, y, x};
   endfunction

   // One-hot layer driver enable for layer z.
   function automatic logic [7:0] layer_onehot(input logic [2:0] z);
      return 8'd1 << z;
   endfunction

endpackage

// File: rtl/cube_layer_driver_if.sv
// Frame handshake from the simulator plus the cube-facing pins of the
// layer driver. The simulator/testbench side is the master.
interface cube_layer_driver_if;
   import cube_pkg::*;

   logic [CELL_BITS-1:0] Cells;
   logic                 FrameValid;
   logic                 FrameAck;
   logic                 SerData;
   logic                 SerClk;
   logic                 SerLatch;
   logic [7:0]           LayerEn;
   logic [2:0]           Layer;

   modport master (
      output Cells, FrameValid,
      input  FrameAck, SerData, SerClk, SerLatch, LayerEn, Layer
   );

   modport slave (
      input  Cells, FrameValid,
      output FrameAck, SerData, SerClk, SerLatch, LayerEn, Layer
   );

endinterface

// File: rtl/cube_shift_serializer.sv
// Shifts one 64-bit column word MSB first. Each bit spends CLK_DIV cycles
// with SerClk low, then CLK_DIV cycles with SerClk high; one extra low
// half-period follows the last bit so the clock is parked before latching.
module cube_shift_serializer
   import cube_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [LAYER_BITS-1:0] word_i,
   output logic                  ser_data_o,
   output logic                  ser_clk_o,
   output logic                  done_o
);

   localparam logic [15:0] HALF_LAST   = 16'(CLK_DIV - 1);
   // Phases 0..127 carry the bits (even = clock low, odd = clock high),
   // phase 128 is the trailing low half-period.
   localparam logic [7:0]  TRAIL_PHASE = 8'd128;

   logic                  busy_q,     busy_d;
   logic [7:0]            phase_q,    phase_d;
   logic [15:0]           half_q,     half_d;
   logic [LAYER_BITS-1:0] shreg_q,    shreg_d;
   logic                  ser_clk_q,  ser_clk_d;
   logic                  ser_data_q, ser_data_d;
   logic [7:0]            phase_next_s;

   assign phase_next_s = phase_q + 8'd1;

   // Next-state logic for the half-period counter, phase counter and pins.
   always_comb begin
      busy_d     = busy_q;
      phase_d    = phase_q;
      half_d     = half_q;
      shreg_d    = shreg_q;
      ser_clk_d  = ser_clk_q;
      ser_data_d = ser_data_q;
      if (start_i) begin
         busy_d     = 1'b1;
         phase_d    = 8'd0;
         half_d     = 16'd0;
         ser_clk_d  = 1'b0;
         ser_data_d = word_i[LAYER_BITS-1];
         shreg_d    = {word_i[LAYER_BITS-2:0], 1'b0};
      end else if (busy_q) begin
         if (half_q == HALF_LAST) begin
            half_d = 16'd0;
            if (phase_q == TRAIL_PHASE) begin
               busy_d     = 1'b0;
               phase_d    = 8'd0;
               ser_clk_d  = 1'b0;
               ser_data_d = 1'b0;
            end else if (phase_next_s == TRAIL_PHASE) begin
               phase_d    = phase_next_s;
               ser_clk_d  = 1'b0;
               ser_data_d = 1'b0;
            end else if (phase_next_s[0] == 1'b0) begin
               // New bit presented while the clock is low.
               phase_d    = phase_next_s;
               ser_clk_d  = 1'b0;
               ser_data_d = shreg_q[LAYER_BITS-1];
               shreg_d    = {shreg_q[LAYER_BITS-2:0], 1'b0};
            end else begin
               phase_d    = phase_next_s;
               ser_clk_d  = 1'b1;
            end
         end else begin
            half_d = half_q + 16'd1;
         end
      end else begin
         ser_clk_d  = 1'b0;
         ser_data_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         phase_q    <= 8'd0;
         half_q     <= 16'd0;
         shreg_q    <= {LAYER_BITS{1'b0}};
         ser_clk_q  <= 1'b0;
         ser_data_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         phase_q    <= phase_d;
         half_q     <= half_d;
         shreg_q    <= shreg_d;
         ser_clk_q  <= ser_clk_d;
         ser_data_q <= ser_data_d;
      end
   end

   assign ser_data_o = ser_data_q;
   assign ser_clk_o  = ser_clk_q;
   // Asserted in the final cycle of the trailing half-period.
   assign done_o     = busy_q && (phase_q == TRAIL_PHASE) && (half_q == HALF_LAST);

endmodule

// File: rtl/cube_layer_driver.sv
// LED cube layer driver: stages incoming frames, swaps them into the
// display buffer only at the layer-0 frame boundary, and scans the cube
// one layer at a time (blank, shift columns, latch, enable layer).
module cube_layer_driver
   import cube_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int ON_CYCLES    = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input logic                Clk,
   input logic                Reset,
   cube_layer_driver_if.slave bus
);

   localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES - 1);
   localparam logic [31:0] LATCH_LAST = 32'(CLK_DIV - 1);
   localparam logic [31:0] ON_LAST    = 32'(ON_CYCLES - 1);
   localparam logic [2:0]  LAST_LAYER = 3'(CUBE_DIM - 1);

   drv_state_e            state_q,     state_d;
   logic [31:0]           cnt_q,       cnt_d;
   logic [2:0]            layer_q,     layer_d;
   logic [CELL_BITS-1:0]  staging_q,   staging_d;
   logic [CELL_BITS-1:0]  display_q,   display_d;
   logic                  pending_q,   pending_d;
   logic                  frame_ack_q, frame_ack_d;
   logic [7:0]            layer_en_q,  layer_en_d;
   logic                  ser_latch_q, ser_latch_d;
   logic                  start_s;
   logic                  ser_done_s;
   logic                  ser_data_s;
   logic                  ser_clk_s;
   logic [LAYER_BITS-1:0] shift_word_s;

   assign shift_word_s = display_q[{layer_q, 6'd0} +: LAYER_BITS];

   cube_shift_serializer #(
      .CLK_DIV (CLK_DIV)
   ) u_serializer (
      .clk        (Clk),
      .rst_n      (Reset),
      .start_i    (start_s),
      .word_i     (shift_word_s),
      .ser_data_o (ser_data_s),
      .ser_clk_o  (ser_clk_s),
      .done_o     (ser_done_s)
   );

   // Scan sequencing, frame staging/transfer and next output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      layer_d     = layer_q;
      staging_d   = staging_q;
      pending_d   = pending_q;
      display_d   = display_q;
      frame_ack_d = 1'b0;
      start_s     = 1'b0;
      if (bus.FrameValid) begin
         staging_d = bus.Cells;
         pending_d = 1'b1;
      end else begin
         staging_d = staging_q;
      end
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = 32'd0;
               state_d = ST_SHIFT;
               start_s = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_SHIFT: begin
            if (ser_done_s) begin
               cnt_d   = 32'd0;
               state_d = ST_LATCH;
            end else begin
               cnt_d = 32'd0;
            end
         end
         ST_LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = 32'd0;
               state_d = ST_DISPLAY;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_DISPLAY: begin
            if (cnt_q == ON_LAST) begin
               cnt_d   = 32'd0;
               state_d = ST_BLANK;
               layer_d = layer_q + 3'd1;
               // Leaving the last layer is the frame boundary: the only
               // point where the shown frame may change, so no tearing.
               if ((layer_q == LAST_LAYER) && (pending_q || bus.FrameValid)) begin
                  display_d   = bus.FrameValid ? bus.Cells : staging_q;
                  pending_d   = 1'b0;
                  frame_ack_d = 1'b1;
               end else begin
                  display_d = display_q;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = 32'd0;
         end
      endcase
      // Pin values follow the next state so they line up with it.
      layer_en_d  = (state_d == ST_DISPLAY) ? layer_onehot(layer_d) : 8'd0;
      ser_latch_d = (state_d == ST_LATCH);
   end

   // All driver state and registered pins, synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= ST_BLANK;
         cnt_q       <= 32'd0;
         layer_q     <= 3'd0;
         staging_q   <= {CELL_BITS{1'b0}};
         display_q   <= {CELL_BITS{1'b0}};
         pending_q   <= 1'b0;
         frame_ack_q <= 1'b0;
         layer_en_q  <= 8'd0;
         ser_latch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         layer_q     <= layer_d;
         staging_q   <= staging_d;
         display_q   <= display_d;
         pending_q   <= pending_d;
         frame_ack_q <= frame_ack_d;
         layer_en_q  <= layer_en_d;
         ser_latch_q <= ser_latch_d;
      end
   end

   assign bus.FrameAck = frame_ack_q;
   assign bus.SerData  = ser_data_s;
   assign bus.SerClk   = ser_clk_s;
   assign bus.SerLatch = ser_latch_q;
   assign bus.LayerEn  = layer_en_q;
   assign bus.Layer    = layer_q;

endmodule
